// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter
//   Two-requester arbiter and sequencer for a W-bit bank of JK flip-flops.
//   A granted command drives the bank's J/K inputs for exactly one cycle
//   (EXEC), then the updated bank value is returned with a one-cycle done
//   pulse to the granted requester (DONE). Peak rate: one command per 3 cycles.
//
//   Build option: define JK_ARB_FIXED_PRIO_EN for fixed priority (requester 0
//   wins ties, no last_grant register). Default is round-robin.
//
// Ports
//   clk              rising-edge clock
//   re               synchronous reset, active-high
//   valid0/1         requester command valid
//   op0/1   [1:0]    opcode: 00 HOLD, 01 CLEAR, 10 SET, 11 TOGGLE
//   mask0/1 [W-1:0]  per-bit mask; masked-off bits get j=k=0
//   ready0/1         command accepted this cycle (IDLE only, winner only)
//   done0/1          result valid pulse for the granted requester
//   rdata   [W-1:0]  bank value returned with done
//   grant_id         requester currently being served
//   busy             high in EXEC and DONE
//   j_out/k_out      J/K inputs driven to the bank (zero outside EXEC)
//   q       [W-1:0]  current bank state

module jk_bank_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         re,
  input  logic         valid0,
  input  logic [1:0]   op0,
  input  logic [W-1:0] mask0,
  output logic         ready0,
  output logic         done0,
  input  logic         valid1,
  input  logic [1:0]   op1,
  input  logic [W-1:0] mask1,
  output logic         ready1,
  output logic         done1,
  output logic [W-1:0] rdata,
  output logic         grant_id,
  output logic         busy,
  output logic [W-1:0] j_out,
  output logic [W-1:0] k_out,
  output logic [W-1:0] q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [1:0]     op_r;
  logic [W-1:0]   mask_r;
  logic           gid_r;
  logic           winner;
  logic           accept;
  logic [W-1:0]   q_nxt;

`ifdef JK_ARB_FIXED_PRIO_EN
  assign winner = ~valid0;
`else
  logic last_grant;

  // On a tie the requester that was not served last wins; otherwise the
  // single valid requester wins (~valid0 selects 1 only when valid0 is low).
  assign winner = (valid0 && valid1) ? ~last_grant : ~valid0;
`endif

  assign busy     = (state != IDLE);
  assign grant_id = gid_r;

  // j/k are zero outside EXEC, so this expression also holds the bank there.
  assign q_nxt = (j_out & ~q) | (~k_out & q);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    j_out     = '0;
    k_out     = '0;
    case (state)
      IDLE: begin
        // Gated by re so ready never advertises an accept that reset overrides.
        if ((valid0 || valid1) && !re) begin
          accept    = 1'b1;
          ready0    = ~winner;
          ready1    = winner;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        j_out     = op_r[1] ? mask_r : '0;
        k_out     = op_r[0] ? mask_r : '0;
        state_nxt = DONE;
      end
      DONE: begin
        done0     = ~gid_r;
        done1     = gid_r;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (re) begin
      state  <= IDLE;
      q      <= '0;
      rdata  <= '0;
      op_r   <= '0;
      mask_r <= '0;
      gid_r  <= 1'b0;
`ifndef JK_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      if (state == EXEC) begin
        rdata <= q_nxt;
      end
      if (accept) begin
        op_r   <= winner ? op1 : op0;
        mask_r <= winner ? mask1 : mask0;
        gid_r  <= winner;
`ifndef JK_ARB_FIXED_PRIO_EN
        last_grant <= winner;
`endif
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
module tb_jk_bank_arbiter;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         re;
  logic         valid0, valid1;
  logic [1:0]   op0, op1;
  logic [W-1:0] mask0, mask1;
  logic         ready0, ready1, done0, done1;
  logic [W-1:0] rdata, j_out, k_out, q;
  logic         grant_id, busy;

  jk_bank_arbiter #(.W(W)) dut (
    .clk(clk), .re(re),
    .valid0(valid0), .op0(op0), .mask0(mask0), .ready0(ready0), .done0(done0),
    .valid1(valid1), .op1(op1), .mask1(mask1), .ready1(ready1), .done1(done1),
    .rdata(rdata), .grant_id(grant_id), .busy(busy),
    .j_out(j_out), .k_out(k_out), .q(q)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { bit id; logic [W-1:0] val; } res_t;
  typedef struct { logic [1:0] op; logic [W-1:0] mask; } cmd_t;

  res_t sb[$];
  cmd_t cq0[$], cq1[$];
  bit   acc0 = 0, acc1 = 0;

  bit           model_ok = 0;
  int           m_phase;   // 0 idle, 1 exec, 2 done
  bit           m_lg, m_gid;
  logic [1:0]   m_op;
  logic [W-1:0] m_mask, m_q, m_rdata;

  function automatic bit m_winner(input bit v0, input bit v1);
`ifdef JK_ARB_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    if (v0 && v1) return (m_lg == 1'b1) ? 1'b0 : 1'b1;
    return v0 ? 1'b0 : 1'b1;
`endif
  endfunction

  function automatic logic [W-1:0] apply(input logic [1:0] op, input logic [W-1:0] m,
                                         input logic [W-1:0] cur);
    case (op)
      2'b00:   return cur;
      2'b01:   return cur & ~m;
      2'b10:   return cur | m;
      default: return cur ^ m;
    endcase
  endfunction

  always @(posedge clk) begin
    if (re) begin
      m_phase = 0; m_q = '0; m_rdata = '0; m_lg = 1'b1; m_gid = 1'b0;
      m_op = '0; m_mask = '0;
      sb.delete();
      model_ok = 1;
    end else if (model_ok) begin
      case (m_phase)
        0: if (valid0 || valid1) begin
          bit w;
          w      = m_winner(valid0, valid1);
          m_gid  = w;
          m_lg   = w;
          m_op   = w ? op1 : op0;
          m_mask = w ? mask1 : mask0;
          if (w) acc1 = 1; else acc0 = 1;
          sb.push_back('{w, apply(m_op, m_mask, m_q)});
          m_phase = 1;
        end
        1: begin
          m_q     = apply(m_op, m_mask, m_q);
          m_rdata = m_q;
          m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle output checks against the model state.
  always @(negedge clk) begin
    #1;
    if (model_ok) begin
      bit any, w;
      any = valid0 || valid1;
      w   = m_winner(valid0, valid1);
      chk("ready0", ready0, (m_phase == 0 && !re && any && w == 1'b0));
      chk("ready1", ready1, (m_phase == 0 && !re && any && w == 1'b1));
      chk("busy", busy, (m_phase != 0));
      chk("done0", done0, (m_phase == 2 && m_gid == 1'b0));
      chk("done1", done1, (m_phase == 2 && m_gid == 1'b1));
      chk("j_out", j_out, (m_phase == 1 && m_op[1]) ? m_mask : '0);
      chk("k_out", k_out, (m_phase == 1 && m_op[0]) ? m_mask : '0);
      chk("q", q, m_q);
      chk("rdata", rdata, m_rdata);
      chk("grant_id", grant_id, m_gid);
    end
  end

  // Scoreboard monitor: pops an expected result whenever the DUT reports done.
  always @(negedge clk) begin
    #2;
    if (done0 || done1) begin
      if (sb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb_unexpected_done: got done0=%0b done1=%0b expected no result", done0, done1);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("sb_id", done1, e.id);
        chk("sb_rdata", rdata, e.val);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    cmd_t c;
    @(negedge clk);
    if (acc0) begin acc0 = 0; valid0 = 1'b0; end
    if (acc1) begin acc1 = 0; valid1 = 1'b0; end
    if (!valid0 && cq0.size() > 0) begin
      c = cq0.pop_front(); op0 = c.op; mask0 = c.mask; valid0 = 1'b1;
    end
    if (!valid1 && cq1.size() > 0) begin
      c = cq1.pop_front(); op1 = c.op; mask1 = c.mask; valid1 = 1'b1;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (cq0.size() == 0 && cq1.size() == 0 && !valid0 && !valid1 && m_phase == 0) begin
        ok = 1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL drain_timeout: got pending work expected idle at %0t", $time);
    end
  endtask

  task automatic wait_exec();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (m_phase == 1) begin ok = 1; break; end
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL exec_timeout: got no EXEC expected EXEC at %0t", $time);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    re = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
    op0 = '0; op1 = '0; mask0 = '0; mask1 = '0;
    repeat (2) cyc();
    re = 1'b0;

    // single SET from requester 0
    cq0.push_back('{2'b10, 8'h0F});
    drain();
    // TOGGLE then CLEAR from requester 1
    cq1.push_back('{2'b11, 8'hFF});
    cq1.push_back('{2'b01, 8'h30});
    drain();
    // contention with HOLD
    for (int i = 0; i < 4; i++) begin
      cq0.push_back('{2'b00, 8'hFF});
      cq1.push_back('{2'b00, 8'hFF});
    end
    drain();
    // masking: reach 0xA5 from 0xC0, then masked-off TOGGLE and full HOLD
    cq0.push_back('{2'b11, 8'h65});
    cq0.push_back('{2'b11, 8'h00});
    cq0.push_back('{2'b00, 8'hFF});
    drain();
    // reset during EXEC, then a tie
    cq0.push_back('{2'b10, 8'hFF});
    wait_exec();
    re = 1'b1;
    cyc();
    re = 1'b0;
    cq0.push_back('{2'b10, 8'h01});
    cq1.push_back('{2'b10, 8'h80});
    drain();
    // requester 1 arrives while requester 0 is executing
    cq0.push_back('{2'b11, 8'h3C});
    wait_exec();
    op1 = 2'b01; mask1 = 8'h0C; valid1 = 1'b1;
    drain();

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      cyc();
      if ($urandom_range(0, 3) == 0 && cq0.size() < 2)
        cq0.push_back('{2'($urandom_range(0, 3)), 8'($urandom)});
      if ($urandom_range(0, 3) == 0 && cq1.size() < 2)
        cq1.push_back('{2'($urandom_range(0, 3)), 8'($urandom)});
      re = ($urandom_range(0, 60) == 0);
    end
    re = 1'b0;
    drain();
    repeat (2) cyc();
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
